// File: rtl/dff_bank_arbiter.sv
// Two-writer register bank with a round-robin grant FSM and a registered read port.
// Each grant lasts one cycle; the write commits on the edge that ends it.
module dff_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [WIDTH-1:0]  D0,
    output logic              Gnt0,
    input  logic              Req1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [WIDTH-1:0]  D1,
    output logic              Gnt1,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [WIDTH-1:0]  Q,
    output logic              Busy
);

    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [WIDTH-1:0] bank_d [DEPTH];

    always_comb begin
        prio_d = prio_q;
        bank_d = bank_q;
        state_d = IDLE;
        q_d = '0;

        // Out-of-range addresses match no entry: write dropped, read returns 0.
        if (state_q == SERVE0 && Req0) begin
            prio_d = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (Addr0 == ADDR_W'(i)) bank_d[i] = D0;
            end
        end
        if (state_q == SERVE1 && Req1) begin
            prio_d = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (Addr1 == ADDR_W'(i)) bank_d[i] = D1;
            end
        end

        // Selection uses the pointer as updated by this edge's commit.
        if (Req0 && Req1) state_d = prio_d ? SERVE1 : SERVE0;
        else if (Req0)    state_d = SERVE0;
        else if (Req1)    state_d = SERVE1;

        for (int i = 0; i < DEPTH; i++) begin
            if (RdAddr == ADDR_W'(i)) q_d = bank_q[i];
        end

        gnt0_d = (state_d == SERVE0);
        gnt1_d = (state_d == SERVE1);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            q_q     <= '0;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= bank_d[i];
        end
    end

    assign Gnt0 = gnt0_q;
    assign Gnt1 = gnt1_q;
    assign Busy = busy_q;
    assign Q    = q_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Bench for dff_bank_arbiter: directed scenarios with literal expectations
// plus random traffic compared every cycle against a behavioural model.
module tb_dff_bank_arbiter;

    logic       Clk;
    logic       Reset;
    logic       Req0, Req1;
    logic [1:0] Addr0, Addr1, RdAddr;
    logic [7:0] D0, D1;
    logic       Gnt0, Gnt1, Busy;
    logic [7:0] Q;

    int ntotal = 0;
    int npass  = 0;

    dff_bank_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Addr0(Addr0), .D0(D0), .Gnt0(Gnt0),
        .Req1(Req1), .Addr1(Addr1), .D1(D1), .Gnt1(Gnt1),
        .RdAddr(RdAddr), .Q(Q), .Busy(Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Model: which requester holds the grant (-1 none), favoured requester, storage.
    int         g;
    int         mprio;
    logic [7:0] mbank [4];
    logic [7:0] mq;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        g = -1;
        mprio = 0;
        mq = 8'h00;
        for (int i = 0; i < 4; i++) mbank[i] = 8'h00;
    endtask

    task automatic model_step();
        logic [7:0] old [4];
        bit         r [2];
        old = mbank;
        r[0] = Req0;
        r[1] = Req1;
        mq = old[RdAddr];
        if (g >= 0 && r[g]) begin
            if (g == 0) mbank[Addr0] = D0;
            else        mbank[Addr1] = D1;
            mprio = 1 - g;
        end
        if (r[0] && r[1]) g = mprio;
        else if (r[0])    g = 0;
        else if (r[1])    g = 1;
        else              g = -1;
    endtask

    always @(posedge Clk) begin
        if (!Reset) model_step();
        #1;
        chk("m_gnt0", 32'(Gnt0), 32'(g == 0));
        chk("m_gnt1", 32'(Gnt1), 32'(g == 1));
        chk("m_busy", 32'(Busy), 32'(g != -1));
        chk("m_q", 32'(Q), 32'(mq));
        chk("m_onehot", 32'(Gnt0 & Gnt1), 32'(0));
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        model_reset();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset  = 1'b1;
        model_reset();
        Req0   = 1'($urandom);
        Req1   = 1'($urandom);
        Addr0  = 2'($urandom);
        Addr1  = 2'($urandom);
        D0     = 8'($urandom);
        D1     = 8'($urandom);
        RdAddr = 2'($urandom);
        #1;
        chk("rst_gnt0", 32'(Gnt0), 32'(0));
        chk("rst_gnt1", 32'(Gnt1), 32'(0));
        chk("rst_busy", 32'(Busy), 32'(0));
        chk("rst_q", 32'(Q), 32'(0));
        tick();
        tick();
        Reset = 1'b0;
        Req0 = 1'b0;
        Req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            RdAddr = 2'(i);
            tick();
            tick();
            chk("rst_read", 32'(Q), 32'(0));
        end

        // Single write of A5 to addr 2, read back two edges after grant.
        Req0 = 1'b1; Addr0 = 2'd2; D0 = 8'hA5; RdAddr = 2'd2;
        tick();
        chk("t2_gnt0_on", 32'(Gnt0), 32'(1));
        chk("t2_busy", 32'(Busy), 32'(1));
        tick();
        Req0 = 1'b0;
        chk("t2_q_old", 32'(Q), 32'(0));
        tick();
        chk("t2_q_new", 32'(Q), 32'(8'hA5));
        tick();
        chk("t2_gnt0_off", 32'(Gnt0), 32'(0));

        // Read-during-write on addr 3: old value first, new one edge later.
        Req1 = 1'b1; Addr1 = 2'd3; D1 = 8'h3C; RdAddr = 2'd3;
        tick();
        chk("t6_gnt1", 32'(Gnt1), 32'(1));
        tick();
        Req1 = 1'b0;
        chk("t6_q_old", 32'(Q), 32'(0));
        tick();
        chk("t6_q_new", 32'(Q), 32'(8'h3C));
        tick();

        // Contention: strict alternation with no idle bubble.
        apply_reset();
        Req0 = 1'b1; Addr0 = 2'd0; D0 = 8'h11;
        Req1 = 1'b1; Addr1 = 2'd1; D1 = 8'h22;
        tick();
        chk("t3_g0a", 32'({Gnt0, Gnt1}), 32'(2'b10));
        tick();
        chk("t3_g1a", 32'({Gnt0, Gnt1}), 32'(2'b01));
        tick();
        chk("t3_g0b", 32'({Gnt0, Gnt1}), 32'(2'b10));
        tick();
        chk("t3_g1b", 32'({Gnt0, Gnt1}), 32'(2'b01));
        Req0 = 1'b0;
        Req1 = 1'b0;
        RdAddr = 2'd0;
        tick();
        tick();
        chk("t3_bank0", 32'(Q), 32'(8'h11));
        RdAddr = 2'd1;
        tick();
        tick();
        chk("t3_bank1", 32'(Q), 32'(8'h22));

        // Withdrawal during grant: no write, priority still with requester 0.
        apply_reset();
        Req0 = 1'b1; Addr0 = 2'd0; D0 = 8'h77; RdAddr = 2'd0;
        tick();
        chk("t4_gnt0", 32'(Gnt0), 32'(1));
        Req0 = 1'b0;
        tick();
        chk("t4_idle", 32'(Busy), 32'(0));
        Req0 = 1'b1; D0 = 8'h55;
        Req1 = 1'b1; Addr1 = 2'd1; D1 = 8'h66;
        tick();
        chk("t4_bank0", 32'(Q), 32'(0));
        chk("t4_prio", 32'({Gnt0, Gnt1}), 32'(2'b10));
        Req0 = 1'b0;
        Req1 = 1'b0;
        tick();
        tick();

        // Async reset mid-SERVE1 kills the grant and the pending write.
        Req1 = 1'b1; Addr1 = 2'd2; D1 = 8'h99; RdAddr = 2'd2;
        tick();
        chk("t5_gnt1_on", 32'(Gnt1), 32'(1));
        #1;
        Reset = 1'b1;
        model_reset();
        #1;
        chk("t5_gnt1_async", 32'(Gnt1), 32'(0));
        chk("t5_busy_async", 32'(Busy), 32'(0));
        tick();
        Reset = 1'b0;
        Req1 = 1'b0;
        tick();
        tick();
        chk("t5_no_write", 32'(Q), 32'(0));

        // Random traffic, occasional resets, checked by the model every cycle.
        for (int n = 0; n < 600; n++) begin
            Req0   = ($urandom_range(0, 3) != 0);
            Req1   = ($urandom_range(0, 3) != 0);
            Addr0  = 2'($urandom);
            Addr1  = 2'($urandom);
            D0     = 8'($urandom);
            D1     = 8'($urandom);
            RdAddr = 2'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                Reset = 1'b1;
                model_reset();
            end else begin
                Reset = 1'b0;
            end
            tick();
        end
        Reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
